// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Purpose:
//   Instruction-fetch sequencing for a single-issue pipeline. Decides, every
//   cycle, what the external PC register loads and whether it may load at
//   all. Redirects come from EX (branch/jump) or from the exception logic
//   (trap). If instruction memory has not returned the word at pc_cur, a
//   redirect cannot be applied yet. In that case it is parked in a
//   single-entry pending slot and applied on the next acknowledge.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   pc_cur     in  32  current PC register value
//   stall      in   1  hazard hold for sequential fetch (never holds a redirect)
//   br_taken   in   1  EX branch/jump resolved taken (one-cycle pulse)
//   br_target  in  32  branch/jump destination, qualified by br_taken
//   trap       in   1  exception request (one-cycle pulse)
//   imem_ack   in   1  instruction word for pc_cur returned this cycle
//   pc_next    out 32  PC register load value
//   pc_pause   out  1  PC register hold (1 = keep value)
//   imem_req   out  1  fetch request for pc_cur
//   flush      out  1  kill IF/ID this cycle
//   redir_cnt  out 16  saturating count of applied redirects
//
// The control outputs are purely combinational from state, pending slot and
// inputs. The PC register would otherwise lose a cycle on every redirect.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic        imem_ack,
  output logic [31:0] pc_next,
  output logic        pc_pause,
  output logic        imem_req,
  output logic        flush,
  output logic [15:0] redir_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pend_tgt_r;
  logic [31:0] pend_tgt_s;
  logic        pend_is_trap_r;
  logic        pend_is_trap_s;
  logic [15:0] redir_cnt_r;

  // Request classification (independent of state)
  logic        bad_align_s;
  logic        req_s;
  logic        req_trap_s;
  logic [31:0] req_tgt_s;

  // Pending slot after merging this cycle's request (used in PEND)
  logic [31:0] merge_tgt_s;
  logic        merge_trap_s;

  // A redirect reached the PC this cycle (pc_pause=0 with a new target)
  logic        apply_s;

  // Classify this cycle's redirect request; a misaligned branch target is handled as a trap.
  always_comb begin
    bad_align_s = br_taken & (br_target[1:0] != 2'b00);
    req_s       = trap | br_taken;
    req_trap_s  = trap | bad_align_s;
    if (req_trap_s) begin
      req_tgt_s = TRAP_VEC;
    end else begin
      req_tgt_s = br_target;
    end
  end

  // Merge a new request into the pending slot: traps always win; a branch
  // replaces a parked branch (newest wins) but never a parked trap.
  always_comb begin
    merge_tgt_s  = pend_tgt_r;
    merge_trap_s = pend_is_trap_r;
    if (req_trap_s) begin
      merge_tgt_s  = TRAP_VEC;
      merge_trap_s = 1'b1;
    end else if (br_taken && !pend_is_trap_r) begin
      merge_tgt_s  = br_target;
      merge_trap_s = 1'b0;
    end else begin
      merge_tgt_s  = pend_tgt_r;
      merge_trap_s = pend_is_trap_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s        = state_r;
    pend_tgt_s     = pend_tgt_r;
    pend_is_trap_s = pend_is_trap_r;
    pc_next        = RESET_VEC;
    pc_pause       = 1'b1;
    imem_req       = 1'b0;
    flush          = 1'b0;
    apply_s        = 1'b0;
    case (state_r)
      BOOT: begin
        // One idle cycle so the PC register settles on RESET_VEC before fetch.
        state_s = RUN;
      end
      RUN: begin
        imem_req = 1'b1;
        if (req_s) begin
          // Redirects ignore stall; they flush regardless of ack.
          flush   = 1'b1;
          pc_next = req_tgt_s;
          if (imem_ack) begin
            pc_pause = 1'b0;
            apply_s  = 1'b1;
          end else begin
            pc_pause       = 1'b1;
            pend_tgt_s     = req_tgt_s;
            pend_is_trap_s = req_trap_s;
            state_s        = PEND;
          end
        end else begin
          pc_next = pc_cur + 32'd4;
          if (imem_ack && !stall) begin
            pc_pause = 1'b0;
          end else begin
            pc_pause = 1'b1;
          end
        end
      end
      PEND: begin
        imem_req = 1'b1;
        pc_next  = merge_tgt_s;
        if (imem_ack) begin
          pc_pause       = 1'b0;
          flush          = 1'b1;
          apply_s        = 1'b1;
          pend_tgt_s     = 32'h0000_0000;
          pend_is_trap_s = 1'b0;
          state_s        = RUN;
        end else begin
          pc_pause       = 1'b1;
          flush          = 1'b0;
          pend_tgt_s     = merge_tgt_s;
          pend_is_trap_s = merge_trap_s;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // State and pending-slot registers; reset discards any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= BOOT;
      pend_tgt_r     <= 32'h0000_0000;
      pend_is_trap_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      pend_tgt_r     <= pend_tgt_s;
      pend_is_trap_r <= pend_is_trap_s;
    end
  end

  // Saturating count of redirects that reached the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_cnt_r <= 16'h0000;
    end else if (apply_s && (redir_cnt_r != 16'hFFFF)) begin
      redir_cnt_r <= redir_cnt_r + 16'd1;
    end else begin
      redir_cnt_r <= redir_cnt_r;
    end
  end

  assign redir_cnt = redir_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Bench for fetch_ctrl. It contains a small PC register model that loads
// pc_next when pc_pause=0. Directed tasks can also force-load it. Every
// negedge, a reference model compares the DUT against the behaviour rules.
// The model tracks a boot flag, a queue of parked redirects and an applied
// count. Literal checks in the stimulus pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic        imem_ack;
  logic [31:0] pc_next;
  logic        pc_pause;
  logic        imem_req;
  logic        flush;
  logic [15:0] redir_cnt;

  logic        pc_set_en;
  logic [31:0] pc_set_val;

  int checks = 0;
  int passes = 0;

  fetch_ctrl #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_cur    (pc_reg),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .trap      (trap),
    .imem_ack  (imem_ack),
    .pc_next   (pc_next),
    .pc_pause  (pc_pause),
    .imem_req  (imem_req),
    .flush     (flush),
    .redir_cnt (redir_cnt)
  );

  always #5 clk = ~clk;

  // External PC register driven by the DUT, with a bench override for setup.
  always @(posedge clk or posedge rst) begin
    if (rst)            pc_reg <= RESET_VEC;
    else if (pc_set_en) pc_reg <= pc_set_val;
    else if (!pc_pause) pc_reg <= pc_next;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] tgt;
    bit          is_trap;
  } pend_t;

  pend_t pend_q[$];
  bit    boot_m = 1'b1;
  int    cnt_m  = 0;

  always @(negedge clk) begin
    logic [31:0] e_next;
    bit          e_pause, e_req, e_flush, do_next, applied, c_trap, c_req;
    logic [31:0] c_tgt;
    pend_t       p;
    applied = 1'b0;
    do_next = 1'b1;
    c_req   = trap || br_taken;
    c_trap  = trap || (br_taken && (br_target[1:0] != 2'b00));
    c_tgt   = c_trap ? TRAP_VEC : br_target;
    if (rst) begin
      cnt_m = 0;
      pend_q.delete();
      boot_m = 1'b1;
      e_next = RESET_VEC; e_pause = 1'b1; e_req = 1'b0; e_flush = 1'b0;
    end else if (boot_m) begin
      e_next = RESET_VEC; e_pause = 1'b1; e_req = 1'b0; e_flush = 1'b0;
    end else begin
      e_req = 1'b1;
      if (pend_q.size() == 0) begin
        if (c_req) begin
          e_flush = 1'b1;
          if (imem_ack) begin
            e_next = c_tgt; e_pause = 1'b0; applied = 1'b1;
          end else begin
            p.tgt = c_tgt; p.is_trap = c_trap;
            pend_q.push_back(p);
            e_next = 32'h0; e_pause = 1'b1; do_next = 1'b0;
          end
        end else begin
          e_next  = pc_reg + 32'd4;
          e_pause = !(imem_ack && !stall);
          e_flush = 1'b0;
        end
      end else begin
        p = pend_q[0];
        if (c_trap) begin
          p.tgt = TRAP_VEC; p.is_trap = 1'b1;
        end else if (br_taken && !p.is_trap) begin
          p.tgt = br_target; p.is_trap = 1'b0;
        end
        if (imem_ack) begin
          e_next = p.tgt; e_pause = 1'b0; e_flush = 1'b1; applied = 1'b1;
          pend_q.delete();
        end else begin
          e_next = 32'h0; e_pause = 1'b1; e_flush = 1'b0; do_next = 1'b0;
          pend_q[0] = p;
        end
      end
    end
    if (do_next) chk("cmp_pc_next", pc_next, e_next);
    chk("cmp_pc_pause", 32'(pc_pause), 32'(e_pause));
    chk("cmp_imem_req", 32'(imem_req), 32'(e_req));
    chk("cmp_flush",    32'(flush),    32'(e_flush));
    chk("cmp_redir_cnt", 32'(redir_cnt), 32'(cnt_m));
    if (!rst) begin
      if (boot_m) boot_m = 1'b0;
      else if (applied && cnt_m < 65535) cnt_m++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic b, input logic [31:0] t,
                     input logic tp, input logic a, input logic s);
    @(posedge clk);
    #1;
    pc_set_en = 1'b0;
    rst = r; br_taken = b; br_target = t; trap = tp; imem_ack = a; stall = s;
    @(negedge clk);
  endtask

  task automatic setpc(input logic [31:0] v);
    @(posedge clk);
    #1;
    rst = 1'b0; br_taken = 1'b0; br_target = 32'h0; trap = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    pc_set_en = 1'b1; pc_set_val = v;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    trap = 1'b0; imem_ack = 1'b1; pc_set_en = 1'b0; pc_set_val = 32'h0;

    // Reset and boot
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_rst_pause", 32'(pc_pause), 32'd1);
    chk("lit_rst_req",   32'(imem_req), 32'd0);
    chk("lit_rst_next",  pc_next, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_boot_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_seq0", pc_reg, 32'h0);
    chk("lit_seq0_next", pc_next, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_seq4", pc_reg, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_seq8", pc_reg, 32'h8);
    chk("lit_seq_cnt", 32'(redir_cnt), 32'd0);

    // Branch with ack overrides stall
    setpc(32'h100);
    cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
    chk("lit_br_next", pc_next, 32'h200);
    chk("lit_br_pause", 32'(pc_pause), 32'd0);
    chk("lit_br_flush", 32'(flush), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_br_cnt", 32'(redir_cnt), 32'd1);

    // Branch without ack: parked, then applied
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    chk("lit_pend_flush", 32'(flush), 32'd1);
    chk("lit_pend_pause", 32'(pc_pause), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("lit_pend_hold", 32'(pc_pause), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_pend_noflush", 32'(flush), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_pend_apply", pc_next, 32'h300);
    chk("lit_pend_apply_flush", 32'(flush), 32'd1);

    // Trap parked while branch pending; later branch ignored
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
    chk("lit_trap_wins", pc_next, 32'h1000);

    // Misaligned target and simultaneous trap+branch
    cyc(1'b0, 1'b1, 32'h202, 1'b0, 1'b1, 1'b0);
    chk("lit_misalign", pc_next, 32'h1000);
    cyc(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    chk("lit_trap_prio", pc_next, 32'h1000);

    // Newest branch wins; redirect in the ack cycle wins
    cyc(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
    chk("lit_newest_br", pc_next, 32'h700);
    cyc(1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h900, 1'b0, 1'b1, 1'b0);
    chk("lit_ack_redirect", pc_next, 32'h900);
    cyc(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h120, 1'b0, 1'b1, 1'b0);
    chk("lit_trap_keeps", pc_next, 32'h1000);
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    chk("lit_cnt8", 32'(redir_cnt), 32'd8);

    // Reset while pending discards the redirect
    cyc(1'b0, 1'b1, 32'hA00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    chk("lit_rst_cnt", 32'(redir_cnt), 32'd0);
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
    chk("lit_reboot_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
    chk("lit_discard_next", pc_next, 32'h4);
    chk("lit_discard_flush", 32'(flush), 32'd0);

    // Wraparound at the top of the address space
    setpc(32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_wrap", pc_next, 32'h0);

    // Mixed pattern sweep (checked by the model)
    for (int i = 0; i < 96; i++) begin
      cyc(1'b0, (i % 5) == 0, (32'(i) << 6) | (((i % 7) == 3) ? 32'h2 : 32'h0),
          (i % 11) == 4, (i % 3) != 0, (i % 4) == 1);
    end

    // Counter saturation
    for (int i = 0; i < 65537; i++) begin
      cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_cnt_sat", 32'(redir_cnt), 32'h0000_FFFF);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_cnt_hold", 32'(redir_cnt), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
